flag_reg_stack: RTL and testbench

- Parametrised successor to the CPU's 3-bit C/Z/B flag register.
- Holds FLAG_W status flags, each with its own update enable, explicit set/clear masks and an optional sticky mode.
- Adds a LIFO save/restore stack of depth STACK_DEPTH, so flags survive CALL/interrupt entry and are restored on return.
- Sits between the ALU flag outputs and the control unit / branch logic.

---
 rtl/flag_reg_stack.sv | 87 ++++++++
 tb/tb_flag_reg_stack.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/flag_reg_stack.sv
// Per-flag C/Z/B(+user) status register with set/clear/sticky update and a LIFO save/restore stack.
// All outputs registered, one-cycle latency; push/pop never stall, misuse raises sticky ovf/unf flags.
module flag_reg_stack #(
   parameter int                FLAG_W      = 3,
   parameter int                STACK_DEPTH = 4,
   parameter logic [FLAG_W-1:0] STICKY_MASK = '0,
   parameter int                CNT_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              flag_rst,
   input  logic [FLAG_W-1:0] flag_we,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic [FLAG_W-1:0] flag_set,
   input  logic [FLAG_W-1:0] flag_clr,
   input  logic              flag_push,
   input  logic              flag_pop,
   input  logic              err_clr,
   output logic [FLAG_W-1:0] flag_out,
   output logic [CNT_W-1:0]  stack_cnt,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_ovf,
   output logic              stack_unf
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [FLAG_W-1:0] stk [STACK_DEPTH];
   logic [FLAG_W-1:0] flag_nxt;
   logic              push_eff;
   logic              pop_eff;
   logic              ovf_evt;
   logic              unf_evt;

   assign stack_full  = (stack_cnt == CNT_W'(STACK_DEPTH));
   assign stack_empty = (stack_cnt == '0);

   // Simultaneous push and pop cancel out: no stack motion and no error.
   assign push_eff = flag_push & ~flag_pop & ~stack_full;
   assign pop_eff  = flag_pop & ~flag_push & ~stack_empty;
   assign ovf_evt  = flag_push & ~flag_pop & stack_full;
   assign unf_evt  = flag_pop & ~flag_push & stack_empty;

   always_comb begin
      flag_nxt = flag_out;
      for (int i = 0; i < FLAG_W; i++) begin
         if (flag_clr[i])
            flag_nxt[i] = 1'b0;
         else if (flag_set[i])
            flag_nxt[i] = 1'b1;
         else if (flag_we[i])
            flag_nxt[i] = STICKY_MASK[i] ? (flag_out[i] | flag_in[i]) : flag_in[i];
      end
   end

   always_ff @(posedge clk or posedge flag_rst) begin
      if (flag_rst) begin
         flag_out  <= '0;
         stack_cnt <= '0;
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++)
            stk[i] <= '0;
      end else begin
         // A restore overrides every ALU/set/clear request in the same cycle.
         flag_out <= pop_eff ? stk[IDX_W'(stack_cnt - CNT_W'(1))] : flag_nxt;

         if (push_eff) begin
            stk[IDX_W'(stack_cnt)] <= flag_out;
            stack_cnt              <= stack_cnt + CNT_W'(1);
         end else if (pop_eff) begin
            stack_cnt <= stack_cnt - CNT_W'(1);
         end

         if (ovf_evt)
            stack_ovf <= 1'b1;
         else if (err_clr)
            stack_ovf <= 1'b0;

         if (unf_evt)
            stack_unf <= 1'b1;
         else if (err_clr)
            stack_unf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flag_reg_stack.sv
// Directed bench for flag_reg_stack: update priority, sticky flag, push/pop, ovf/unf and async reset.
module tb_flag_reg_stack;

   localparam int FLAG_W = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              flag_rst;
   logic [FLAG_W-1:0] flag_we;
   logic [FLAG_W-1:0] flag_in;
   logic [FLAG_W-1:0] flag_set;
   logic [FLAG_W-1:0] flag_clr;
   logic              flag_push;
   logic              flag_pop;
   logic              err_clr;
   logic [FLAG_W-1:0] flag_out;
   logic [CNT_W-1:0]  stack_cnt;
   logic              stack_full;
   logic              stack_empty;
   logic              stack_ovf;
   logic              stack_unf;

   int checks = 0;
   int errors = 0;

   flag_reg_stack #(
      .FLAG_W      (FLAG_W),
      .STACK_DEPTH (DEPTH),
      .STICKY_MASK (3'b100)
   ) dut (
      .clk         (clk),
      .flag_rst    (flag_rst),
      .flag_we     (flag_we),
      .flag_in     (flag_in),
      .flag_set    (flag_set),
      .flag_clr    (flag_clr),
      .flag_push   (flag_push),
      .flag_pop    (flag_pop),
      .err_clr     (err_clr),
      .flag_out    (flag_out),
      .stack_cnt   (stack_cnt),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_ovf   (stack_ovf),
      .stack_unf   (stack_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, sample 1 time unit after the rising edge, then idle the inputs.
   task automatic cyc(input logic [2:0] we, input logic [2:0] din, input logic [2:0] set,
                      input logic [2:0] clr, input logic push, input logic pop, input logic ec);
      flag_we   = we;
      flag_in   = din;
      flag_set  = set;
      flag_clr  = clr;
      flag_push = push;
      flag_pop  = pop;
      err_clr   = ec;
      @(posedge clk);
      #1;
      flag_we   = '0;
      flag_in   = '0;
      flag_set  = '0;
      flag_clr  = '0;
      flag_push = 1'b0;
      flag_pop  = 1'b0;
      err_clr   = 1'b0;
   endtask

   task automatic chk_state(input string tag, input logic [2:0] f, input int cnt,
                            input logic ovf, input logic unf);
      chk({tag, "_flags"}, 8'(flag_out), 8'(f));
      chk({tag, "_cnt"},   8'(stack_cnt), 8'(cnt));
      chk({tag, "_full"},  8'(stack_full), 8'(cnt == DEPTH));
      chk({tag, "_empty"}, 8'(stack_empty), 8'(cnt == 0));
      chk({tag, "_ovf"},   8'(stack_ovf), 8'(ovf));
      chk({tag, "_unf"},   8'(stack_unf), 8'(unf));
   endtask

   initial begin
      flag_rst  = 1'b1;
      flag_we   = '0;
      flag_in   = '0;
      flag_set  = '0;
      flag_clr  = '0;
      flag_push = 1'b0;
      flag_pop  = 1'b0;
      err_clr   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_state("reset", 3'b000, 0, 1'b0, 1'b0);
      flag_rst = 1'b0;

      // ALU update and hold
      cyc(3'b111, 3'b101, 3'b000, 3'b000, 0, 0, 0);
      chk("alu_upd", 8'(flag_out), 8'h5);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0);
      chk("alu_hold", 8'(flag_out), 8'h5);

      // clear beats set beats write
      cyc(3'b111, 3'b111, 3'b000, 3'b010, 0, 0, 0);
      chk("prio_clr_we", 8'(flag_out), 8'h5);
      cyc(3'b000, 3'b000, 3'b010, 3'b010, 0, 0, 0);
      chk("prio_clr_set", 8'(flag_out), 8'h5);

      // bit2 is sticky: write cannot clear it, explicit clear can
      cyc(3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 0);
      chk("sticky_pre", 8'(flag_out), 8'h4);
      cyc(3'b111, 3'b001, 3'b000, 3'b000, 0, 0, 0);
      chk("sticky_we", 8'(flag_out), 8'h5);
      cyc(3'b000, 3'b000, 3'b000, 3'b100, 0, 0, 0);
      chk("sticky_clr", 8'(flag_out), 8'h1);

      // push/pop round trip
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0);
      chk_state("push1", 3'b001, 1, 1'b0, 1'b0);
      cyc(3'b000, 3'b000, 3'b110, 3'b001, 0, 0, 0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0);
      chk_state("push2", 3'b110, 2, 1'b0, 1'b0);
      cyc(3'b000, 3'b000, 3'b000, 3'b111, 0, 0, 0);
      chk("zeroed", 8'(flag_out), 8'h0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0);
      chk_state("pop1", 3'b110, 1, 1'b0, 1'b0);
      cyc(3'b111, 3'b111, 3'b000, 3'b000, 0, 1, 0);
      chk_state("pop_we", 3'b001, 0, 1'b0, 1'b0);

      // overflow: snapshots 001,010,011,100, flags change on each push
      cyc(3'b000, 3'b000, 3'b010, 3'b101, 1, 0, 0);
      cyc(3'b000, 3'b000, 3'b011, 3'b100, 1, 0, 0);
      cyc(3'b000, 3'b000, 3'b100, 3'b011, 1, 0, 0);
      cyc(3'b000, 3'b000, 3'b101, 3'b010, 1, 0, 0);
      chk_state("push4", 3'b101, 4, 1'b0, 1'b0);
      cyc(3'b000, 3'b000, 3'b110, 3'b001, 1, 0, 0);
      chk_state("push_ovf", 3'b110, 4, 1'b1, 1'b0);

      // drain; top must be the 4th snapshot
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0);
      chk_state("drain4", 3'b100, 3, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0);
      chk_state("drain3", 3'b011, 2, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0);
      chk_state("drain2", 3'b010, 1, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0);
      chk_state("drain1", 3'b001, 0, 1'b1, 1'b0);
      // pop on empty: normal update applies, underflow raised
      cyc(3'b111, 3'b010, 3'b000, 3'b000, 0, 1, 0);
      chk_state("pop_unf", 3'b010, 0, 1'b1, 1'b1);

      // err_clr loses to a same-cycle underflow but clears ovf
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 1);
      chk_state("errclr_race", 3'b010, 0, 1'b0, 1'b1);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 1);
      chk_state("errclr", 3'b010, 0, 1'b0, 1'b0);

      // push+pop together cancel
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 1, 1, 0);
      chk_state("push_pop", 3'b010, 2, 1'b0, 1'b0);
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0);
      chk_state("push3", 3'b010, 3, 1'b0, 1'b0);

      // asynchronous reset mid-cycle, no clock edge in between
      #2;
      flag_rst = 1'b1;
      #1;
      chk_state("async_rst", 3'b000, 0, 1'b0, 1'b0);
      @(negedge clk);
      flag_rst = 1'b0;
      cyc(3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0);
      chk_state("post_rst_pop", 3'b000, 0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
